// File: rtl/tri_intersect_seq.sv
// Purpose: time-shares one circle-pair intersection datapath across the (A,B), (B,C), (C,A) pairs of a job.
// Latency: out_valid rises 3*LAT cycles after the accept edge; each zero-radius pair takes 1 cycle instead of LAT.
// Backpressure: results are held in DONE until out_ready; no new job is accepted before returning to IDLE.
module tri_intersect_seq #(
  parameter int N   = 8,
  parameter int LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3*N:0]      a_in,
  input  logic [3*N:0]      b_in,
  input  logic [3*N:0]      c_in,
  output logic [3*N:0]      dp_g,
  output logic [3*N:0]      dp_e,
  input  logic [14*N+33:0]  dp_o,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [14*N+33:0]  res_ab,
  output logic [14*N+33:0]  res_bc,
  output logic [14*N+33:0]  res_ca,
  output logic [2:0]        res_skip,
  output logic              busy
);

  localparam logic [3:0] LAST = 4'(LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [3*N:0]   circ_a;
  logic [3*N:0]   circ_b;
  logic [3*N:0]   circ_c;
  logic [1:0]     pair;
  logic [3:0]     cnt;
  logic           pair_skip;
  logic           pair_end;

  // A pair with a zero radius on either operand cannot intersect; it is skipped in one cycle.
  assign pair_skip = (dp_g[N:0] == '0) || (dp_e[N:0] == '0);
  assign pair_end  = pair_skip || (cnt == LAST);

  // Ready is held low during reset so nothing is accepted on the reset edge.
  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  // Sequencer: latch the job, walk the three pairs, then hold results for the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      circ_a    <= '0;
      circ_b    <= '0;
      circ_c    <= '0;
      pair      <= '0;
      cnt       <= '0;
      dp_g      <= '0;
      dp_e      <= '0;
      res_ab    <= '0;
      res_bc    <= '0;
      res_ca    <= '0;
      res_skip  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            circ_a <= a_in;
            circ_b <= b_in;
            circ_c <= c_in;
            pair   <= 2'd0;
            cnt    <= 4'd0;
            dp_g   <= a_in;
            dp_e   <= b_in;
            state  <= RUN;
          end
        end
        RUN: begin
          if (pair_end) begin
            case (pair)
              2'd0:    res_ab <= pair_skip ? '0 : dp_o;
              2'd1:    res_bc <= pair_skip ? '0 : dp_o;
              default: res_ca <= pair_skip ? '0 : dp_o;
            endcase
            res_skip[pair] <= pair_skip;
            cnt            <= 4'd0;
            if (pair == 2'd2) begin
              state     <= DONE;
              out_valid <= 1'b1;
              dp_g      <= '0;
              dp_e      <= '0;
            end else begin
              pair <= pair + 2'd1;
              if (pair == 2'd0) begin
                dp_g <= circ_b;
                dp_e <= circ_c;
              end else begin
                dp_g <= circ_c;
                dp_e <= circ_a;
              end
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_intersect_seq.sv
// Purpose: directed bench for tri_intersect_seq with LAT=2, 4 and 1 instances and a delayed-tag datapath model.
// Latency: expected results are queued at accept and compared when the DUT presents them.
// Backpressure: out_ready is held low for a stretch to observe result stability and the bubble cycle.
module tb_tri_intersect_seq;

  localparam int N  = 8;
  localparam int CW = 3*N + 1;
  localparam int RW = 14*N + 34;

  typedef struct packed {
    logic [RW-1:0] ab;
    logic [RW-1:0] bc;
    logic [RW-1:0] ca;
    logic [2:0]    skip;
  } exp_t;

  logic          clk = 1'b0;
  int            cyc = 0;
  logic          rst       [3];
  logic          in_valid  [3];
  logic          in_ready  [3];
  logic [CW-1:0] a_in      [3];
  logic [CW-1:0] b_in      [3];
  logic [CW-1:0] c_in      [3];
  logic [CW-1:0] dp_g      [3];
  logic [CW-1:0] dp_e      [3];
  logic [RW-1:0] dp_o      [3];
  logic          out_valid [3];
  logic          out_ready [3];
  logic [RW-1:0] res_ab    [3];
  logic [RW-1:0] res_bc    [3];
  logic [RW-1:0] res_ca    [3];
  logic [2:0]    res_skip  [3];
  logic          busy      [3];

  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Order-sensitive tag so a swapped or stale operand pair is visible in the result.
  function automatic logic [RW-1:0] tag(input logic [CW-1:0] g, input logic [CW-1:0] e);
    return {g, e, ~g, g ^ e, g[CW-5:0], e};
  endfunction

  function automatic logic [CW-1:0] circ(input logic [7:0] x, input logic [7:0] y, input logic [8:0] r);
    return {x, y, r};
  endfunction

  function automatic exp_t mk(input logic [CW-1:0] a, input logic [CW-1:0] b, input logic [CW-1:0] c);
    exp_t e;
    e.skip[0] = (a[N:0] == 0) || (b[N:0] == 0);
    e.skip[1] = (b[N:0] == 0) || (c[N:0] == 0);
    e.skip[2] = (c[N:0] == 0) || (a[N:0] == 0);
    e.ab = e.skip[0] ? '0 : tag(a, b);
    e.bc = e.skip[1] ? '0 : tag(b, c);
    e.ca = e.skip[2] ? '0 : tag(c, a);
    return e;
  endfunction

  genvar k;
  for (k = 0; k < 3; k++) begin : g_dut
    localparam int L = (k == 0) ? 2 : (k == 1) ? 4 : 1;
    logic [RW-1:0] pipe [16];

    tri_intersect_seq #(.N(N), .LAT(L)) dut (
      .clk      (clk),
      .rst      (rst[k]),
      .in_valid (in_valid[k]),
      .in_ready (in_ready[k]),
      .a_in     (a_in[k]),
      .b_in     (b_in[k]),
      .c_in     (c_in[k]),
      .dp_g     (dp_g[k]),
      .dp_e     (dp_e[k]),
      .dp_o     (dp_o[k]),
      .out_valid(out_valid[k]),
      .out_ready(out_ready[k]),
      .res_ab   (res_ab[k]),
      .res_bc   (res_bc[k]),
      .res_ca   (res_ca[k]),
      .res_skip (res_skip[k]),
      .busy     (busy[k])
    );

    // Datapath model: result of the operands seen L cycles earlier.
    always @(posedge clk) begin
      pipe[0] <= tag(dp_g[k], dp_e[k]);
      for (int j = 1; j < 16; j++) pipe[j] <= pipe[j-1];
    end

    if (L == 1) begin : g_comb
      assign dp_o[k] = tag(dp_g[k], dp_e[k]);
    end else begin : g_pipe
      assign dp_o[k] = pipe[L-2];
    end
  end

  task automatic chk_i(input string name, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic chk_out(input int k);
    exp_t e;
    chk_i("sb_nonempty", int'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk_w("res_ab", res_ab[k], e.ab);
      chk_w("res_bc", res_bc[k], e.bc);
      chk_w("res_ca", res_ca[k], e.ca);
      chk_i("res_skip", int'(res_skip[k]), int'(e.skip));
    end
  endtask

  // Called at the first negedge after the accept edge; counts edges until out_valid, then drains.
  task automatic wait_out(input int k, input int exp_lat);
    int lat = 0;
    while (!out_valid[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk_i("latency", lat, exp_lat);
    chk_out(k);
    out_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[k] = 1'b0;
  endtask

  logic [CW-1:0] ca, cb, cc, d1, d2, d3;
  logic [CW-1:0] pg [3];
  logic [CW-1:0] pe [3];
  logic [RW-1:0] snap;
  int            acc [$];
  int            hs  [$];
  int            seen;
  logic          took;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; in_valid[i] = 1'b0; out_ready[i] = 1'b0;
      a_in[i] = '0; b_in[i] = '0; c_in[i] = '0;
    end

    // Reset then idle
    @(negedge clk);
    chk_i("rst_in_ready", int'(in_ready[0]), 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_i("idle_in_ready", int'(in_ready[i]), 1);
      chk_i("idle_busy", int'(busy[i]), 0);
      chk_i("idle_out_valid", int'(out_valid[i]), 0);
      chk_i("idle_dp_g", int'(dp_g[i]), 0);
      chk_i("idle_dp_e", int'(dp_e[i]), 0);
      chk_w("idle_res_ab", res_ab[i], '0);
      chk_w("idle_res_bc", res_bc[i], '0);
      chk_w("idle_res_ca", res_ca[i], '0);
      chk_i("idle_res_skip", int'(res_skip[i]), 0);
    end

    // Nominal job, LAT=2
    ca = circ(8'h00, 8'h00, 9'd100);
    cb = circ(8'hE0, 8'd108, 9'd215);
    cc = circ(8'hF0, 8'h91, 9'd236);
    pg[0] = ca; pe[0] = cb; pg[1] = cb; pe[1] = cc; pg[2] = cc; pe[2] = ca;
    a_in[0] = ca; b_in[0] = cb; c_in[0] = cc; in_valid[0] = 1'b1;
    sb.push_back(mk(ca, cb, cc));
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk_i("nom_dp_g", int'(dp_g[0]), int'(pg[i/2]));
      chk_i("nom_dp_e", int'(dp_e[0]), int'(pe[i/2]));
      chk_i("nom_out_valid_low", int'(out_valid[0]), 0);
      @(negedge clk);
    end
    chk_i("nom_out_valid", int'(out_valid[0]), 1);
    chk_i("nom_done_dp_g", int'(dp_g[0]), 0);
    chk_out(0);

    // Backpressure with a new job offered
    snap = res_ab[0];
    d1 = circ(8'h11, 8'h22, 9'd33);
    d2 = circ(8'h44, 8'h55, 9'd66);
    d3 = circ(8'h77, 8'h88, 9'd99);
    a_in[0] = d1; b_in[0] = d2; c_in[0] = d3; in_valid[0] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk_i("bp_in_ready", int'(in_ready[0]), 0);
      chk_i("bp_out_valid", int'(out_valid[0]), 1);
      chk_w("bp_res_ab_stable", res_ab[0], snap);
    end
    chk_w("bp_res_bc", res_bc[0], tag(cb, cc));
    chk_w("bp_res_ca", res_ca[0], tag(cc, ca));
    out_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[0] = 1'b0;
    chk_i("bubble_out_valid", int'(out_valid[0]), 0);
    chk_i("bubble_in_ready", int'(in_ready[0]), 1);
    sb.push_back(mk(d1, d2, d3));
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    wait_out(0, 6);

    // Zero radius on B, LAT=4
    ca = circ(8'd10, 8'd20, 9'd30);
    cb = circ(8'd5, 8'd6, 9'd0);
    cc = circ(8'h80, 8'h7F, 9'd300);
    a_in[1] = ca; b_in[1] = cb; c_in[1] = cc; in_valid[1] = 1'b1;
    sb.push_back(mk(ca, cb, cc));
    @(posedge clk);
    @(negedge clk);
    in_valid[1] = 1'b0;
    wait_out(1, 6);

    // Reset during pair 1, LAT=4
    ca = circ(8'd1, 8'd2, 9'd3);
    cb = circ(8'd4, 8'd5, 9'd6);
    cc = circ(8'd7, 8'd8, 9'd9);
    a_in[1] = ca; b_in[1] = cb; c_in[1] = cc; in_valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[1] = 1'b0;
    repeat (5) @(negedge clk);
    chk_i("mid_pair1_dp_g", int'(dp_g[1]), int'(cb));
    rst[1] = 1'b1;
    #1;
    chk_i("mid_rst_in_ready", int'(in_ready[1]), 0);
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    #1;
    chk_i("abort_busy", int'(busy[1]), 0);
    chk_i("abort_in_ready", int'(in_ready[1]), 1);
    chk_i("abort_dp_g", int'(dp_g[1]), 0);
    chk_w("abort_res_ab", res_ab[1], '0);
    chk_w("abort_res_ca", res_ca[1], '0);
    chk_i("abort_res_skip", int'(res_skip[1]), 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid[1]) seen++;
    end
    chk_i("abort_no_out_valid", seen, 0);

    // LAT=1 back-to-back with in_valid and out_ready held high
    a_in[2] = circ(8'h12, 8'h34, 9'd56);
    b_in[2] = circ(8'hAB, 8'hCD, 9'd78);
    c_in[2] = circ(8'hFE, 8'h01, 9'd90);
    in_valid[2] = 1'b1;
    out_ready[2] = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      took = in_valid[2] && in_ready[2];
      if (took) begin
        acc.push_back(cyc + 1);
        sb.push_back(mk(a_in[2], b_in[2], c_in[2]));
      end
      if (out_valid[2] && out_ready[2]) begin
        hs.push_back(cyc + 1);
        chk_out(2);
      end
      @(negedge clk);
      if (took) begin
        if (acc.size() == 1) begin
          a_in[2] = circ(8'h21, 8'h43, 9'd65);
          b_in[2] = circ(8'hBA, 8'hDC, 9'd87);
          c_in[2] = circ(8'hEF, 8'h10, 9'd9);
        end else begin
          in_valid[2] = 1'b0;
        end
      end
      #1;
    end
    out_ready[2] = 1'b0;
    chk_i("b2b_counts", int'(acc.size()) * 10 + int'(hs.size()), 22);
    if (acc.size() == 2 && hs.size() == 2) begin
      chk_i("b2b_lat0", hs[0] - 1 - acc[0], 3);
      chk_i("b2b_gap", acc[1] - hs[0], 1);
      chk_i("b2b_lat1", hs[1] - 1 - acc[1], 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
